// File: rtl/csr_timer_int.sv
// Exception-configuration/status CSRs, a countdown timer with interrupt flag,
// and a 64-bit free-running counter, all behind a single CSR access port.
module csr_timer_int #(
    parameter int HW_INT_NUM  = 8,
    parameter int TIMER_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  csr_we,
    input  logic [13:0]           csr_num,
    input  logic [31:0]           csr_wmask,
    input  logic [31:0]           csr_wvalue,
    output logic [31:0]           csr_rvalue,
    output logic                  csr_hit,
    input  logic [HW_INT_NUM-1:0] hw_int_in,
    input  logic                  ipi_int_in,
    input  logic                  crmd_ie,
    output logic                  has_int,
    output logic [63:0]           stable_cnt
);

    localparam logic [13:0] CSR_ECFG  = 14'h004;
    localparam logic [13:0] CSR_ESTAT = 14'h005;
    localparam logic [13:0] CSR_TID   = 14'h040;
    localparam logic [13:0] CSR_TCFG  = 14'h041;
    localparam logic [13:0] CSR_TVAL  = 14'h042;
    localparam logic [13:0] CSR_TICLR = 14'h044;

    // Software bits 1:0, timer 11, IPI 12, plus one bit per implemented hw line.
    localparam logic [12:0] LIE_MASK = 13'h1803 | 13'(((1 << HW_INT_NUM) - 1) << 2);

    logic [12:0]            lie_q, lie_d;
    logic [1:0]             is_sw_q, is_sw_d;
    logic [HW_INT_NUM-1:0]  is_hw_q, is_hw_d;
    logic                   ti_q, ti_d;
    logic                   ipi_q, ipi_d;
    logic [31:0]            tid_q, tid_d;
    logic [TIMER_WIDTH-1:0] tcfg_q, tcfg_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic                   stopped_q, stopped_d;
    logic [63:0]            stable_cnt_q, stable_cnt_d;

    logic [12:0]            is_vec;
    logic                   wr_ecfg, wr_estat, wr_tid, wr_tcfg, wr_ticlr;
    logic                   ti_clear, expire;
    logic [31:0]            ecfg_m, estat_m;

    always_comb begin
        is_vec                  = '0;
        is_vec[1:0]             = is_sw_q;
        is_vec[2 +: HW_INT_NUM] = is_hw_q;
        is_vec[11]              = ti_q;
        is_vec[12]              = ipi_q;
    end

    always_comb begin
        csr_hit    = 1'b1;
        csr_rvalue = '0;
        case (csr_num)
            CSR_ECFG:  csr_rvalue = {19'b0, lie_q};
            CSR_ESTAT: csr_rvalue = {19'b0, is_vec};
            CSR_TID:   csr_rvalue = tid_q;
            CSR_TCFG:  csr_rvalue = 32'(tcfg_q);
            CSR_TVAL:  csr_rvalue = 32'(timer_q);
            CSR_TICLR: csr_rvalue = '0;
            default:   csr_hit    = 1'b0;
        endcase
    end

    always_comb begin
        wr_ecfg  = csr_we && (csr_num == CSR_ECFG);
        wr_estat = csr_we && (csr_num == CSR_ESTAT);
        wr_tid   = csr_we && (csr_num == CSR_TID);
        wr_tcfg  = csr_we && (csr_num == CSR_TCFG);
        wr_ticlr = csr_we && (csr_num == CSR_TICLR);

        ecfg_m  = ({19'b0, lie_q} & ~csr_wmask) | (csr_wvalue & csr_wmask);
        estat_m = ({30'b0, is_sw_q} & ~csr_wmask) | (csr_wvalue & csr_wmask);

        lie_d   = wr_ecfg  ? (ecfg_m[12:0] & LIE_MASK) : lie_q;
        is_sw_d = wr_estat ? estat_m[1:0] : is_sw_q;
        is_hw_d = hw_int_in;
        ipi_d   = ipi_int_in;
        tid_d   = wr_tid ? ((tid_q & ~csr_wmask) | (csr_wvalue & csr_wmask)) : tid_q;
        tcfg_d  = wr_tcfg ? ((tcfg_q & ~csr_wmask[TIMER_WIDTH-1:0]) |
                             (csr_wvalue[TIMER_WIDTH-1:0] & csr_wmask[TIMER_WIDTH-1:0]))
                          : tcfg_q;

        // A TCFG write in the expiry cycle reloads the timer and suppresses TI.
        expire    = tcfg_q[0] && !stopped_q && (timer_q == '0) && !wr_tcfg;
        ti_clear  = wr_ticlr && csr_wvalue[0] && csr_wmask[0];
        timer_d   = timer_q;
        stopped_d = stopped_q;
        if (wr_tcfg) begin
            timer_d   = {tcfg_d[TIMER_WIDTH-1:2], 2'b00};
            stopped_d = 1'b0;
        end else if (tcfg_q[0] && !stopped_q) begin
            if (timer_q != '0) begin
                timer_d = timer_q - TIMER_WIDTH'(1);
            end else if (tcfg_q[1]) begin
                timer_d = {tcfg_q[TIMER_WIDTH-1:2], 2'b00};
            end else begin
                timer_d   = '1;
                stopped_d = 1'b1;
            end
        end

        ti_d         = expire ? 1'b1 : (ti_clear ? 1'b0 : ti_q);
        stable_cnt_d = stable_cnt_q + 64'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // its _d value from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lie_q        <= '0;
            is_sw_q      <= '0;
            is_hw_q      <= '0;
            ti_q         <= 1'b0;
            ipi_q        <= 1'b0;
            tid_q        <= '0;
            tcfg_q       <= '0;
            timer_q      <= '0;
            stopped_q    <= 1'b0;
            stable_cnt_q <= '0;
        end else begin
            lie_q        <= lie_d;
            is_sw_q      <= is_sw_d;
            is_hw_q      <= is_hw_d;
            ti_q         <= ti_d;
            ipi_q        <= ipi_d;
            tid_q        <= tid_d;
            tcfg_q       <= tcfg_d;
            timer_q      <= timer_d;
            stopped_q    <= stopped_d;
            stable_cnt_q <= stable_cnt_d;
        end
    end

    assign has_int    = crmd_ie & (|(is_vec & lie_q));
    assign stable_cnt = stable_cnt_q;

endmodule

// File: tb/tb_csr_timer_int.sv
// Scoreboard bench for csr_timer_int: expectations are queued as stimulus is
// applied and popped when the corresponding DUT output is sampled.
module tb_csr_timer_int;

    localparam logic [13:0] ECFG  = 14'h004;
    localparam logic [13:0] ESTAT = 14'h005;
    localparam logic [13:0] TID   = 14'h040;
    localparam logic [13:0] TCFG  = 14'h041;
    localparam logic [13:0] TVAL  = 14'h042;
    localparam logic [13:0] TICLR = 14'h044;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        csr_we = 1'b0;
    logic [13:0] csr_num = '0;
    logic [31:0] csr_wmask = '0;
    logic [31:0] csr_wvalue = '0;
    logic [31:0] csr_rvalue, csr_rvalue2;
    logic        csr_hit, csr_hit2;
    logic [7:0]  hw_int_in = '0;
    logic        ipi_int_in = 1'b0;
    logic        crmd_ie = 1'b0;
    logic        has_int, has_int2;
    logic [63:0] stable_cnt, stable_cnt2;
    longint      cyc = 0;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    string       tag_q[$];

    csr_timer_int #(.HW_INT_NUM(8), .TIMER_WIDTH(32)) dut (
        .clk(clk), .reset(reset), .csr_we(csr_we), .csr_num(csr_num),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue),
        .csr_hit(csr_hit), .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .crmd_ie(crmd_ie), .has_int(has_int), .stable_cnt(stable_cnt)
    );

    csr_timer_int #(.HW_INT_NUM(2), .TIMER_WIDTH(32)) dut2 (
        .clk(clk), .reset(reset), .csr_we(csr_we), .csr_num(csr_num),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .csr_rvalue(csr_rvalue2),
        .csr_hit(csr_hit2), .hw_int_in(hw_int_in[1:0]), .ipi_int_in(ipi_int_in),
        .crmd_ie(crmd_ie), .has_int(has_int2), .stable_cnt(stable_cnt2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [63:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop(input logic [63:0] got);
        if (exp_q.size() == 0) check("sb_underflow", 64'd1, 64'd0);
        else check(tag_q.pop_front(), got, exp_q.pop_front());
    endtask

    // Writes are launched in the low clock phase and land on the next rising edge.
    task automatic csr_wr(input logic [13:0] a, input logic [31:0] v, input logic [31:0] m);
        csr_we = 1'b1; csr_num = a; csr_wvalue = v; csr_wmask = m;
        @(negedge clk);
        csr_we = 1'b0; csr_wmask = '0;
    endtask

    task automatic rd(input logic [13:0] a, input logic [31:0] exp, input string tag);
        sb_push(tag, {32'b0, exp});
        csr_num = a;
        #1;
        sb_pop({32'b0, csr_rvalue});
    endtask

    task automatic wait_rise(output longint at);
        int n = 0;
        while (!has_int && n < 40) begin
            @(negedge clk);
            n++;
        end
        sb_push("has_int_rise", 64'd1);
        sb_pop({63'b0, has_int});
        at = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint t0, t1;
        logic [63:0] exp_cnt;

        // Reset state
        #1;
        rd(ECFG, 32'h0, "rst_ecfg");
        rd(ESTAT, 32'h0, "rst_estat");
        rd(TCFG, 32'h0, "rst_tcfg");
        sb_push("rst_has_int", 64'd0); sb_pop({63'b0, has_int});
        sb_push("rst_stable_cnt", 64'd0); sb_pop(stable_cnt);
        @(negedge clk);
        reset = 1'b0;

        // One-shot countdown from 16
        csr_wr(TCFG, 32'h0000_0011, 32'hFFFF_FFFF);
        for (int k = 0; k <= 16; k++) begin
            rd(TVAL, 32'(16 - k), "oneshot_tval");
            @(negedge clk);
        end
        rd(TVAL, 32'hFFFF_FFFF, "oneshot_expired_tval");
        rd(ESTAT, 32'h800, "oneshot_ti");
        @(negedge clk);
        rd(TVAL, 32'hFFFF_FFFF, "oneshot_stays_tval");
        rd(ESTAT, 32'h800, "oneshot_stays_ti");
        sb_push("oneshot_no_lie_has_int", 64'd0); sb_pop({63'b0, has_int});

        // Periodic: 17-cycle interrupt period, reload to 16
        csr_wr(TICLR, 32'h1, 32'h1);
        csr_wr(ECFG, 32'h800, 32'hFFFF_FFFF);
        crmd_ie = 1'b1;
        csr_wr(TCFG, 32'h0000_0013, 32'hFFFF_FFFF);
        wait_rise(t0);
        rd(TVAL, 32'd16, "periodic_reload_tval");
        for (int p = 0; p < 2; p++) begin
            csr_wr(TICLR, 32'h1, 32'h1);
            sb_push("periodic_cleared", 64'd0); sb_pop({63'b0, has_int});
            wait_rise(t1);
            sb_push("periodic_interval", 64'd17); sb_pop(64'(t1 - t0));
            t0 = t1;
        end

        // TICLR coinciding with expiry: set wins; TICLR alone clears
        csr_wr(TICLR, 32'h1, 32'h1);
        repeat (15) @(negedge clk);
        rd(TVAL, 32'd0, "coincide_tval_zero");
        sb_push("coincide_pre_has_int", 64'd0); sb_pop({63'b0, has_int});
        csr_wr(TICLR, 32'h1, 32'h1);
        rd(ESTAT, 32'h800, "coincide_ti_kept");
        sb_push("coincide_has_int", 64'd1); sb_pop({63'b0, has_int});
        csr_wr(TICLR, 32'h1, 32'h1);
        rd(ESTAT, 32'h0, "ticlr_alone_ti");
        sb_push("ticlr_alone_has_int", 64'd0); sb_pop({63'b0, has_int});
        rd(TICLR, 32'h0, "ticlr_reads_zero");

        // Stop timer, TVAL writes ignored, TID masking
        csr_wr(TCFG, 32'h0, 32'hFFFF_FFFF);
        csr_wr(TVAL, 32'h1234, 32'hFFFF_FFFF);
        rd(TVAL, 32'h0, "tval_write_ignored");
        csr_wr(TID, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        rd(TID, 32'hDEAD_BEEF, "tid_full");
        csr_wr(TID, 32'h0, 32'hFFFF_0000);
        rd(TID, 32'h0000_BEEF, "tid_masked");

        // ESTAT software bits: only masked bit0 lands, TI/IPI not writable
        csr_wr(ESTAT, 32'hFFFF_FFFF, 32'h0000_0001);
        rd(ESTAT, 32'h1, "estat_sw_masked");
        csr_wr(ECFG, 32'h1, 32'h1);
        sb_push("sw_int_has_int", 64'd1); sb_pop({63'b0, has_int});
        csr_wr(ESTAT, 32'h0, 32'h3);
        rd(ESTAT, 32'h0, "estat_sw_cleared");

        // ECFG writable-bit masks for both HW_INT_NUM settings; address decode
        csr_wr(ECFG, 32'h1FFF, 32'hFFFF_FFFF);
        rd(ECFG, 32'h1BFF, "ecfg_hw8");
        sb_push("ecfg_hw2", 64'h180F); sb_pop({32'b0, csr_rvalue2});
        sb_push("hit_ecfg", 64'd1); sb_pop({63'b0, csr_hit});
        rd(14'h100, 32'h0, "miss_rvalue");
        sb_push("miss_hit", 64'd0); sb_pop({63'b0, csr_hit});
        sb_push("miss_hit2", 64'd0); sb_pop({63'b0, csr_hit2});
        sb_push("miss_rvalue2", 64'd0); sb_pop({32'b0, csr_rvalue2});

        // Hardware interrupt line 3 -> IS[5], gated by crmd_ie
        csr_wr(ECFG, 32'h20, 32'hFFFF_FFFF);
        crmd_ie = 1'b0;
        hw_int_in = 8'h08;
        rd(ESTAT, 32'h0, "hw_int_latency");
        @(negedge clk);
        rd(ESTAT, 32'h20, "hw_int_estat");
        sb_push("hw_int_ie0", 64'd0); sb_pop({63'b0, has_int});
        crmd_ie = 1'b1;
        #1;
        sb_push("hw_int_ie1", 64'd1); sb_pop({63'b0, has_int});
        sb_push("hw_int_dut2_unused_line", 64'd0); sb_pop({63'b0, has_int2});
        hw_int_in = 8'h00;
        ipi_int_in = 1'b1;
        @(negedge clk);
        rd(ESTAT, 32'h1000, "ipi_estat");
        ipi_int_in = 1'b0;
        @(negedge clk);

        // stable_cnt wrap from a preloaded value near the top
        dut.stable_cnt_q <= 64'hFFFF_FFFF_FFFF_FFFD;
        #1;
        exp_cnt = 64'hFFFF_FFFF_FFFF_FFFD;
        sb_push("cnt_preload", exp_cnt); sb_pop(stable_cnt);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            exp_cnt = exp_cnt + 64'd1;
            sb_push("cnt_wrap", exp_cnt); sb_pop(stable_cnt);
        end

        // Reset asserted mid-countdown
        csr_wr(ECFG, 32'h800, 32'hFFFF_FFFF);
        csr_wr(TID, 32'h55, 32'hFFFF_FFFF);
        csr_wr(TCFG, 32'h0000_0011, 32'hFFFF_FFFF);
        repeat (5) @(negedge clk);
        rd(TVAL, 32'd11, "mid_countdown_tval");
        #1;
        reset = 1'b1;
        #1;
        rd(TVAL, 32'h0, "areset_tval");
        rd(TCFG, 32'h0, "areset_tcfg");
        rd(ECFG, 32'h0, "areset_ecfg");
        rd(TID, 32'h0, "areset_tid");
        rd(ESTAT, 32'h0, "areset_estat");
        sb_push("areset_cnt", 64'd0); sb_pop(stable_cnt);
        sb_push("areset_cnt2", 64'd0); sb_pop(stable_cnt2);
        sb_push("areset_has_int", 64'd0); sb_pop({63'b0, has_int});
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        rd(TVAL, 32'h0, "post_reset_tval");
        rd(ESTAT, 32'h0, "post_reset_no_ti");
        sb_push("post_reset_cnt", 64'd20); sb_pop(stable_cnt);

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
